// File: rtl/camera_ctrl.sv
// camera_ctrl: capture sequencer for the 2x2 pixel camera.
// Holds the user exposure setting, steps the pixel array through
// erase (IDLE), timer load, exposure and a two-row readout with ADC
// strobes, and configures and enables the external exposure timer.
module camera_ctrl #(
    parameter int EXP_MIN   = 2,
    parameter int EXP_MAX   = 30,   // timer loads exp_time+1 into 5 bits, so <= 30
    parameter int EXP_RESET = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       exp_increase,
    input  logic       exp_decrease,
    input  logic       exposure_done,
    output logic       set_time,
    output logic       timer_enable,
    output logic [4:0] timer_init,
    output logic [4:0] exp_time,
    output logic       erase,
    output logic       expose,
    output logic       nre_1,
    output logic       nre_2,
    output logic       adc,
    output logic       busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPOSE = 2'd2;
    localparam logic [1:0] S_READ   = 2'd3;

    localparam logic [4:0] C_EXP_MIN   = 5'(EXP_MIN);
    localparam logic [4:0] C_EXP_MAX   = 5'(EXP_MAX);
    localparam logic [4:0] C_EXP_RESET = 5'(EXP_RESET);

    logic [1:0] r_state;
    logic [2:0] r_step;
    logic [4:0] r_exp_time;

    logic       w_adjust_ok;
    logic       w_inc_only;
    logic       w_dec_only;

    // Adjustments only count in IDLE with no capture request; init wins a tie.
    assign w_adjust_ok = (r_state == S_IDLE) && !init;
    assign w_inc_only  = exp_increase && !exp_decrease;
    assign w_dec_only  = exp_decrease && !exp_increase;

    // Sequencer state transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (init) r_state <= S_LOAD;
                S_LOAD:   r_state <= S_EXPOSE;
                S_EXPOSE: if (exposure_done) r_state <= S_READ;
                S_READ:   if (r_step == 3'd7) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Readout step counter: held at zero outside READ so it starts clean on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step <= 3'd0;
        end else if (r_state == S_READ) begin
            r_step <= r_step + 3'd1;
        end else begin
            r_step <= 3'd0;
        end
    end

    // Exposure setting with saturation at both ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp_time <= C_EXP_RESET;
        end else if (w_adjust_ok) begin
            if (w_inc_only && (r_exp_time < C_EXP_MAX)) begin
                r_exp_time <= r_exp_time + 5'd1;
            end else if (w_dec_only && (r_exp_time > C_EXP_MIN)) begin
                r_exp_time <= r_exp_time - 5'd1;
            end else begin
                r_exp_time <= r_exp_time;
            end
        end else begin
            r_exp_time <= r_exp_time;
        end
    end

    assign exp_time   = r_exp_time;
    assign timer_init = r_exp_time;

    // Moore decode of pixel array, ADC and timer controls from state and step.
    always_comb begin
        erase        = 1'b0;
        expose       = 1'b0;
        nre_1        = 1'b1;
        nre_2        = 1'b1;
        adc          = 1'b0;
        set_time     = 1'b0;
        timer_enable = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                erase = 1'b1;
                busy  = 1'b0;
            end
            S_LOAD: begin
                set_time = 1'b1;
            end
            S_EXPOSE: begin
                timer_enable = 1'b1;
                expose       = !exposure_done;
            end
            S_READ: begin
                case (r_step)
                    3'd0, 3'd2: nre_1 = 1'b0;
                    3'd1: begin
                        nre_1 = 1'b0;
                        adc   = 1'b1;
                    end
                    3'd4, 3'd6: nre_2 = 1'b0;
                    3'd5: begin
                        nre_2 = 1'b0;
                        adc   = 1'b1;
                    end
                    default: begin
                        nre_1 = 1'b1;
                        nre_2 = 1'b1;
                    end
                endcase
            end
            default: begin
                erase = 1'b1;
                busy  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_camera_ctrl.sv
// Testbench for camera_ctrl with a behavioural model of the external timer.
module tb_camera_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       exp_increase = 1'b0;
    logic       exp_decrease = 1'b0;
    logic       exposure_done;
    logic       set_time, timer_enable, erase, expose, nre_1, nre_2, adc, busy;
    logic [4:0] timer_init, exp_time;
    logic [4:0] tcnt;

    int tests_run = 0;
    int tests_failed = 0;

    camera_ctrl dut (
        .clk(clk), .reset(reset), .init(init),
        .exp_increase(exp_increase), .exp_decrease(exp_decrease),
        .exposure_done(exposure_done), .set_time(set_time),
        .timer_enable(timer_enable), .timer_init(timer_init),
        .exp_time(exp_time), .erase(erase), .expose(expose),
        .nre_1(nre_1), .nre_2(nre_2), .adc(adc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Timer model: load init+1, count down to zero while enabled.
    always @(posedge clk or posedge reset) begin
        if (reset) tcnt <= 5'd0;
        else if (set_time) tcnt <= timer_init + 5'd1;
        else if (timer_enable && tcnt != 5'd0) tcnt <= tcnt - 5'd1;
    end
    assign exposure_done = (tcnt == 5'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one capture and records per-cycle observations (idx 0 = LOAD cycle).
    task automatic capture(input int reinit_idx, input int dec_from, input int stop_idx,
                           output int busy_n, output int set_n, output int exp_n,
                           output int exp_first, output int n1_n, output int n1_first,
                           output int n2_n, output int n2_first, output int adc_n,
                           output int adc_a, output int adc_b, output int overlap,
                           output int tload);
        busy_n = 0; set_n = 0; exp_n = 0; exp_first = -1; n1_n = 0; n1_first = -1;
        n2_n = 0; n2_first = -1; adc_n = 0; adc_a = -1; adc_b = -1; overlap = 0; tload = -1;
        init = 1'b1;
        step();
        init = 1'b0;
        for (int idx = 0; idx < 80; idx++) begin
            if (idx == stop_idx) return;
            if (!busy) break;
            busy_n++;
            if (idx == 1) tload = int'(tcnt);
            if (set_time) set_n++;
            if (expose) begin exp_n++; if (exp_first < 0) exp_first = idx; end
            if (!nre_1) begin n1_n++; if (n1_first < 0) n1_first = idx; end
            if (!nre_2) begin n2_n++; if (n2_first < 0) n2_first = idx; end
            if (!nre_1 && !nre_2) overlap++;
            if (adc) begin
                adc_n++;
                if (adc_a < 0) adc_a = idx; else adc_b = idx;
            end
            init = (idx == reinit_idx);
            exp_decrease = (dec_from >= 0) && (idx >= dec_from);
            step();
        end
        init = 1'b0;
        exp_decrease = 1'b0;
    endtask

    int bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl;

    // Checks the whole capture timeline for exposure T.
    task automatic check_capture(input string nm, input int T);
        tests_run++;
        if (bn !== T + 11) begin tests_failed++; $display("FAIL %s busy_cycles got %0d exp %0d", nm, bn, T + 11); end
        tests_run++;
        if (sn !== 1) begin tests_failed++; $display("FAIL %s set_time_cycles got %0d exp 1", nm, sn); end
        tests_run++;
        if (en !== T + 1 || ef !== 1) begin tests_failed++; $display("FAIL %s expose got %0d@%0d exp %0d@1", nm, en, ef, T + 1); end
        tests_run++;
        if (n1 !== 3 || n1f !== T + 3) begin tests_failed++; $display("FAIL %s nre_1 got %0d@%0d exp 3@%0d", nm, n1, n1f, T + 3); end
        tests_run++;
        if (n2 !== 3 || n2f !== T + 7) begin tests_failed++; $display("FAIL %s nre_2 got %0d@%0d exp 3@%0d", nm, n2, n2f, T + 7); end
        tests_run++;
        if (an !== 2 || aa !== T + 4 || ab !== T + 8) begin
            tests_failed++; $display("FAIL %s adc got %0d@%0d,%0d exp 2@%0d,%0d", nm, an, aa, ab, T + 4, T + 8);
        end
        tests_run++;
        if (ov !== 0) begin tests_failed++; $display("FAIL %s nre_overlap got %0d exp 0", nm, ov); end
        tests_run++;
        if (tl !== T + 1) begin tests_failed++; $display("FAIL %s timer_load got %0d exp %0d", nm, tl, T + 1); end
        tests_run++;
        if (erase !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL %s erase_after got erase=%b busy=%b exp 1/0", nm, erase, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12 reset = 1'b0;
        step();
        tests_run++;
        if (exp_time !== 5'd10 || erase !== 1'b1 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_defaults got exp=%0d erase=%b busy=%b exp 10/1/0", exp_time, erase, busy);
        end
        exp_increase = 1'b1;
        step();
        exp_increase = 1'b0;
        tests_run++;
        if (exp_time !== 5'd11) begin tests_failed++; $display("FAIL adjust_latency got %0d exp 11", exp_time); end
        init = 1'b1;
        step();
        init = 1'b0;
        step(); step();
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if ({erase, expose, nre_1, nre_2, adc, set_time, timer_enable, busy} !== 8'b1011_0000 ||
            exp_time !== 5'd10 || timer_init !== 5'd10) begin
            tests_failed++;
            $display("FAIL async_reset got outs=%b exp=%0d tinit=%0d exp 10110000/10/10",
                     {erase, expose, nre_1, nre_2, adc, set_time, timer_enable, busy}, exp_time, timer_init);
        end
        #2 reset = 1'b0;
        step();
    endtask

    task automatic test_nominal();
        capture(-1, -1, -1, bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl);
        check_capture("nominal_T10", 10);
    endtask

    task automatic test_init_with_adjust();
        exp_increase = 1'b1;
        capture(-1, -1, -1, bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl);
        exp_increase = 1'b0;
        tests_run++;
        if (bn !== 21) begin tests_failed++; $display("FAIL init_wins_busy got %0d exp 21", bn); end
        tests_run++;
        if (exp_time !== 5'd10) begin tests_failed++; $display("FAIL init_wins_exp got %0d exp 10", exp_time); end
    endtask

    task automatic test_back_to_back();
        capture(5, -1, -1, bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl);
        check_capture("reinit_expose", 10);
        step(); step();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reinit_queued got busy=%b exp 0", busy); end
    endtask

    task automatic test_dec_in_read();
        capture(-1, 13, -1, bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl);
        tests_run++;
        if (exp_time !== 5'd10) begin tests_failed++; $display("FAIL dec_in_read got %0d exp 10", exp_time); end
    endtask

    task automatic test_reset_mid_read();
        exp_increase = 1'b1;
        step(); step();
        exp_increase = 1'b0;
        tests_run++;
        if (exp_time !== 5'd12) begin tests_failed++; $display("FAIL pre_mid_reset got %0d exp 12", exp_time); end
        capture(-1, -1, 19, bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl);
        tests_run++;
        if (nre_2 !== 1'b0) begin tests_failed++; $display("FAIL read_step4 nre_2 got %b exp 0", nre_2); end
        #3 reset = 1'b1;
        #1;
        tests_run++;
        if (nre_2 !== 1'b1 || busy !== 1'b0 || erase !== 1'b1 || exp_time !== 5'd10) begin
            tests_failed++;
            $display("FAIL mid_reset got nre_2=%b busy=%b erase=%b exp=%0d exp 1/0/1/10", nre_2, busy, erase, exp_time);
        end
        #2 reset = 1'b0;
        step();
        capture(-1, -1, -1, bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl);
        check_capture("after_mid_reset", 10);
    endtask

    task automatic test_saturation();
        exp_increase = 1'b1;
        repeat (40) step();
        exp_increase = 1'b0;
        tests_run++;
        if (exp_time !== 5'd30 || timer_init !== 5'd30) begin
            tests_failed++; $display("FAIL sat_max got %0d/%0d exp 30", exp_time, timer_init);
        end
        exp_decrease = 1'b1;
        repeat (40) step();
        exp_decrease = 1'b0;
        tests_run++;
        if (exp_time !== 5'd2) begin tests_failed++; $display("FAIL sat_min got %0d exp 2", exp_time); end
        exp_increase = 1'b1;
        repeat (3) step();
        exp_decrease = 1'b1;
        repeat (5) step();
        exp_increase = 1'b0;
        exp_decrease = 1'b0;
        tests_run++;
        if (exp_time !== 5'd5) begin tests_failed++; $display("FAIL both_high got %0d exp 5", exp_time); end
    endtask

    task automatic test_boundary();
        exp_increase = 1'b1;
        repeat (40) step();
        exp_increase = 1'b0;
        tests_run++;
        if (timer_init !== 5'd30) begin tests_failed++; $display("FAIL bound_tinit got %0d exp 30", timer_init); end
        capture(-1, -1, -1, bn, sn, en, ef, n1, n1f, n2, n2f, an, aa, ab, ov, tl);
        check_capture("boundary_T30", 30);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_init_with_adjust();
        test_back_to_back();
        test_dec_in_read();
        test_reset_mid_read();
        test_saturation();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/camera_ctrl.md
# camera_ctrl

Top-level capture sequencer for the 2x2 pixel camera. Holds the user exposure setting and steps the array through three phases: erase (idle), exposure timed by the external `timer_counter`, and a two-row readout with ADC strobes. It drives the pixel array control lines and configures and enables the exposure timer.

## Interface
- `EXP_MIN`, default 2: lowest allowed exposure setting, in clocks.
- `EXP_MAX`, default 30: highest allowed exposure setting. Must be ≤ 30, because the timer loads `init+1` into 5 bits.
- `EXP_RESET`, default 10: exposure setting after reset.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `init` in 1: capture request, sampled in IDLE.
- `exp_increase` in 1: raise the exposure setting by 1 per clock while high in IDLE.
- `exp_decrease` in 1: lower the exposure setting by 1 per clock while high in IDLE.
- `exposure_done` in 1: from `timer_counter`, high when its count is 0.
- `set_time` out 1: timer load strobe.
- `timer_enable` out 1: timer count enable.
- `timer_init` out 5: timer load value. Always equals `exp_time`.
- `exp_time` out 5: current exposure setting.
- `erase` out 1: pixel erase, active-high.
- `expose` out 1: pixel expose, active-high.
- `nre_1` out 1: row 1 read enable, active-low.
- `nre_2` out 1: row 2 read enable, active-low.
- `adc` out 1: ADC sample strobe, active-high, one clock wide.
- `busy` out 1: high in any state other than IDLE.

## Operation
States and transitions:
- IDLE → LOAD when `init` is high.
- LOAD → EXPOSE unconditionally.
- EXPOSE → READ when `exposure_done` is sampled high.
- READ → IDLE after readout step 7.
- READ uses a 3-bit step counter. It clears on entry and increments every clock.

Outputs, all Moore decode of state and step:
- IDLE: `erase`=1. All other outputs are inactive.
- LOAD: `set_time`=1. `erase`=0.
- EXPOSE: `timer_enable`=1. `expose` = NOT `exposure_done`.
- READ steps 0–2: `nre_1`=0. `adc`=1 at step 1 only.
- READ step 3: both `nre` lines high (row gap).
- READ steps 4–6: `nre_2`=0. `adc`=1 at step 5 only.
- READ step 7: all lines inactive. Return to IDLE follows.
- `nre_1` and `nre_2` are never low in the same cycle.

Exposure setting (register `exp_time`):
- Updates only in IDLE, and only when `init` is low.
- Increase alone: `exp_time+1`, saturating at EXP_MAX.
- Decrease alone: `exp_time-1`, saturating at EXP_MIN.
- Both high: no change.
- `init` and an adjust input high together: `init` wins and the adjust is discarded.
- Adjust inputs are ignored while `busy`.

Other rules:
- `init` while `busy` is ignored. Requests are not queued.
- Reset at any point: asynchronous return to IDLE and `exp_time`=EXP_RESET. No readout is completed.
- The timer's internal state does not matter after reset, because LOAD always precedes EXPOSE.

## Timing
Reset values:
- State IDLE, step 0, `exp_time`=EXP_RESET.
- `erase`=1, `expose`=0, `nre_1`=1, `nre_2`=1, `adc`=0.
- `set_time`=0, `timer_enable`=0, `busy`=0.
- `timer_init`=EXP_RESET.

Capture timeline, with T = `exp_time`:
- `init` is sampled high at edge E0. LOAD occupies cycle E0→E1.
- The timer holds T+1 after E1.
- `expose` is high for exactly T+1 cycles, starting at E1.
- `exposure_done` rises after E1+T+1. The EXPOSE state lasts T+2 cycles, and in its last cycle `expose` is already 0.
- READ lasts 8 cycles.
- `busy` is high for 1 + (T+2) + 8 = T+11 cycles.
- First `erase` cycle after capture is at E1+T+10.

Adjustment latency:
- The new `exp_time` is visible the cycle after the sampling edge.
- `timer_init` tracks `exp_time` combinationally.

## Test plan
- Reset and defaults: assert `reset` mid-cycle, then release. Required: all outputs at their reset values immediately (asynchronous), and `exp_time`=10.
- Nominal capture with T=10: pulse `init` for 1 cycle. Required:
  - `set_time` high for 1 cycle.
  - `expose` high for 11 cycles.
  - `nre_1` low for 3 cycles with `adc` in the middle cycle, then a 1-cycle gap.
  - `nre_2` low for 3 cycles with `adc` in the middle cycle.
  - `busy` high for 21 cycles, then `erase`=1.
- Saturation: hold `exp_increase` for 40 cycles, then `exp_time`=30. Hold `exp_decrease` for 40 cycles, then `exp_time`=2. Both high, then unchanged.
- Guarded inputs:
  - `init` and `exp_increase` together at T=10: capture starts and `exp_time` stays 10.
  - `init` re-pulsed during EXPOSE: ignored, and exactly one readout occurs.
  - `exp_decrease` during READ: no change.
- Boundary exposure: T=30 capture. Required: `timer_init`=30, `expose` high for 31 cycles, no timer wrap.
- Reset mid-operation: assert `reset` in READ step 4. Required: `nre_2` returns high asynchronously, state is IDLE, `exp_time`=10, and the next `init` performs a full capture.
